// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: instruction fields, FSM states and ALU ops.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;
  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;

  typedef enum logic [2:0] {
    StBoot   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluSrl
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational 32-bit ALU; shifts act on operand b by shamt.
module mc_alu
  import mips_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = a_i + b_i;
    unique case (op_i)
      AluAdd:  y_o = a_i + b_i;
      AluSub:  y_o = a_i - b_i;
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluSlt:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      AluSll:  y_o = b_i << shamt_i;
      AluSrl:  y_o = b_i >> shamt_i;
      default: y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core with a single req/ready memory port, jr support and a sticky trap state.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned ADDR_W           = 32,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pcout,
  output logic [31:0]       instruction,
  output logic [2:0]        state_dbg,
  output logic              retired,
  output logic              trap
);

  state_e      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  wb_dest;
  logic [31:0] imm_sext, alu_b, alu_y, jump_pc, wb_data;
  logic        legal, is_jr, is_ctrl, is_mem, misaligned;
  alu_op_e     alu_op;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign imm_sext = sext16(ir_q[15:0]);
  assign is_jr    = (opcode == OpRtype) && (funct == FnJr);
  assign is_ctrl  = is_jr || (opcode inside {OpJ, OpJal, OpBeq, OpBne});
  assign is_mem   = (opcode == OpLw) || (opcode == OpSw);
  assign misaligned = alu_y[1:0] != 2'b00;
  assign wb_dest  = (opcode == OpRtype) ? ir_q[15:11] : ir_q[20:16];
  assign wb_data  = (opcode == OpLw) ? mdr_q : alu_out_q;

  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OpRtype: legal = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnSll, FnSrl, FnJr};
      OpJ, OpJal, OpBeq, OpBne, OpAddi, OpLw, OpSw: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = AluAdd;
    alu_b  = imm_sext;
    if (opcode == OpRtype) begin
      alu_b = b_q;
      unique case (funct)
        FnSub:   alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        FnSlt:   alu_op = AluSlt;
        FnSll:   alu_op = AluSll;
        FnSrl:   alu_op = AluSrl;
        default: alu_op = AluAdd;
      endcase
    end
  end

  // alu_out_q holds the branch target computed during decode.
  always_comb begin
    jump_pc = pc_q;
    unique case (opcode)
      OpRtype:      jump_pc = a_q;
      OpJ, OpJal:   jump_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
      OpBeq, OpBne: jump_pc = ((a_q == b_q) ^ (opcode == OpBne)) ? alu_out_q : pc_q;
      default:      jump_pc = pc_q;
    endcase
  end

  mc_alu u_alu (
    .op_i    (alu_op),
    .a_i     (a_q),
    .b_i     (alu_b),
    .shamt_i (ir_q[10:6]),
    .y_o     (alu_y)
  );

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retired   <= 1'b0;
      trap      <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      retired <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q  <= StFetch;
          mem_req  <= 1'b1;
          mem_addr <= pc_q[ADDR_W-1:0];
        end
        StFetch: if (mem_ready) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + 32'd4;
          mem_req <= 1'b0;
          state_q <= StDecode;
        end
        StDecode: begin
          a_q       <= rf_q[ir_q[25:21]];
          b_q       <= rf_q[ir_q[20:16]];
          alu_out_q <= pc_q + (imm_sext << 2);
          state_q   <= legal ? StExec : StTrap;
          trap      <= !legal;
        end
        StExec: begin
          if (is_ctrl) begin
            pc_q     <= jump_pc;
            retired  <= 1'b1;
            state_q  <= StFetch;
            mem_req  <= 1'b1;
            mem_addr <= jump_pc[ADDR_W-1:0];
            if (opcode == OpJal) rf_q[31] <= pc_q;
          end else if (is_mem) begin
            alu_out_q <= alu_y;
            if (misaligned && TRAP_ON_MISALIGN) begin
              state_q <= StTrap;
              trap    <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OpSw);
              mem_addr  <= {alu_y[ADDR_W-1:2], 2'b00};
              mem_wdata <= b_q;
              state_q   <= StMem;
            end
          end else begin
            alu_out_q <= alu_y;
            state_q   <= StWb;
          end
        end
        StMem: if (mem_ready) begin
          mem_we <= 1'b0;
          if (opcode == OpSw) begin
            // mem_req stays high: the next fetch follows back-to-back.
            retired  <= 1'b1;
            state_q  <= StFetch;
            mem_addr <= pc_q[ADDR_W-1:0];
          end else begin
            mdr_q   <= mem_rdata;
            mem_req <= 1'b0;
            state_q <= StWb;
          end
        end
        StWb: begin
          if (wb_dest != 5'd0) rf_q[wb_dest] <= wb_data;
          retired  <= 1'b1;
          state_q  <= StFetch;
          mem_req  <= 1'b1;
          mem_addr <= pc_q[ADDR_W-1:0];
        end
        StTrap: begin
          trap    <= 1'b1;
          mem_req <= 1'b0;
        end
        default: begin
          state_q <= StTrap;
          trap    <= 1'b1;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign pcout       = pc_q;
  assign instruction = ir_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: directed programs, trap paths, reset abort and a random program,
// each retirement compared with an instruction-level reference model.
module tb_mips_multicycle;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retired, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pcout, instruction;
  logic [2:0]  state_dbg;

  mips_multicycle #(
    .RESET_PC         (ResetPc),
    .ADDR_W           (32),
    .TRAP_ON_MISALIGN (1'b1)
  ) dut (
    .clock       (clock),
    .Reset       (Reset),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .pcout       (pcout),
    .instruction (instruction),
    .state_dbg   (state_dbg),
    .retired     (retired),
    .trap        (trap)
  );

  always #5 clock = ~clock;

  logic [31:0] mem   [1024];
  logic [31:0] mmem  [1024];
  logic [31:0] mregs [32];
  logic [31:0] mpc;
  logic [31:0] last_waddr, last_wdata, hold_addr;
  int n_assert = 0, n_fail = 0;
  int age, delay, waits, cyc_since, n_retired, n_xfers, n_writes, hold_delay;
  bit rand_waits, hold_en;
  logic [5:0] alu_fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                        input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int target);
    return {6'(op), 26'(target)};
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) mregs[idx] = val;
  endtask

  // Architectural step: one whole instruction, plus its zero-wait cycle count.
  task automatic model_step(output int lat, output logic [31:0] word);
    logic [31:0] rs, rt, simm, npc, ea;
    word = mmem[mpc[11:2]];
    rs   = mregs[word[25:21]];
    rt   = mregs[word[20:16]];
    simm = {{16{word[15]}}, word[15:0]};
    npc  = mpc + 32'd4;
    ea   = rs + simm;
    lat  = 4;
    case (word[31:26])
      6'h00: case (word[5:0])
        6'h20: wr(word[15:11], rs + rt);
        6'h22: wr(word[15:11], rs - rt);
        6'h24: wr(word[15:11], rs & rt);
        6'h25: wr(word[15:11], rs | rt);
        6'h2A: wr(word[15:11], ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0);
        6'h00: wr(word[15:11], rt << word[10:6]);
        6'h02: wr(word[15:11], rt >> word[10:6]);
        6'h08: begin npc = rs; lat = 3; end
        default: lat = -1;
      endcase
      6'h08: wr(word[20:16], rs + simm);
      6'h23: begin wr(word[20:16], mmem[ea[11:2]]); lat = 5; end
      6'h2B: mmem[ea[11:2]] = rt;
      6'h04: begin if (rs == rt) npc = npc + (simm << 2); lat = 3; end
      6'h05: begin if (rs != rt) npc = npc + (simm << 2); lat = 3; end
      6'h02: begin npc = {npc[31:28], word[25:0], 2'b00}; lat = 3; end
      6'h03: begin mregs[31] = npc; npc = {npc[31:28], word[25:0], 2'b00}; lat = 3; end
      default: lat = -1;
    endcase
    mpc = npc;
  endtask

  task automatic on_retire();
    int lat;
    logic [31:0] word;
    model_step(lat, word);
    check("retire_ir", instruction, word);
    check("retire_pc", pcout, mpc);
    check("retire_cycles", 32'(cyc_since), 32'(lat + waits));
    check("retire_trap", 32'(trap), 32'd0);
    n_retired++;
    cyc_since = 0;
    waits = 0;
  endtask

  // One clock: drive the memory side, take the edge, check just after it.
  task automatic tick();
    logic stall;
    logic [31:0] a0, d0;
    logic w0;
    if (mem_req) begin
      if (age == 0) begin
        if (hold_en && mem_addr == hold_addr && !mem_we) begin
          delay = hold_delay;
          hold_en = 1'b0;
        end else if (rand_waits && $urandom_range(0, 2) == 0) delay = $urandom_range(1, 3);
        else delay = 0;
      end
      mem_ready = (age >= delay);
      age = mem_ready ? 0 : age + 1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      age = 0;
    end
    mem_rdata = mem[mem_addr[11:2]];
    stall = mem_req && !mem_ready;
    if (stall) waits++;
    if (mem_req && mem_ready) begin
      n_xfers++;
      if (mem_we) begin
        mem[mem_addr[11:2]] = mem_wdata;
        n_writes++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
    end
    a0 = mem_addr; w0 = mem_we; d0 = mem_wdata;
    @(posedge clock);
    #1;
    cyc_since++;
    if (stall) begin
      check("hold_req", 32'(mem_req), 32'd1);
      check("hold_addr", mem_addr, a0);
      check("hold_we", 32'(mem_we), 32'(w0));
      check("hold_wdata", mem_wdata, d0);
    end
    if (retired) on_retire();
  endtask

  task automatic enter_reset();
    #2 Reset = 1'b0;
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", pcout, ResetPc);
    check("rst_ir", instruction, 32'd0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mpc = ResetPc;
    rand_waits = 1'b0;
    hold_en = 1'b0;
  endtask

  task automatic release_reset();
    for (int i = 0; i < 1024; i++) mmem[i] = mem[i];
    repeat (2) @(posedge clock);
    @(negedge clock);
    Reset = 1'b1;
    age = 0; waits = 0; cyc_since = -1;
    n_retired = 0; n_xfers = 0; n_writes = 0;
    #1 check("boot_req_low", 32'(mem_req), 32'd0);
    tick();
    check("boot_fetch_req", 32'(mem_req), 32'd1);
    check("boot_fetch_addr", mem_addr, ResetPc);
    check("boot_state", 32'(state_dbg), 32'd1);
  endtask

  task automatic run(input int target, input int budget);
    int c = 0;
    while (n_retired < target && c < budget) begin
      tick();
      c++;
    end
    check("retire_count", 32'(n_retired), 32'(target));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 1; i < 32; i++) check(tag, dut.rf_q[i], mregs[i]);
  endtask

  task automatic check_trap(input string tag);
    repeat (12) tick();
    check({tag, "_trap"}, 32'(trap), 32'd1);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_pc"}, pcout, ResetPc + 32'd4);
    check({tag, "_xfers"}, 32'(n_xfers), 32'd1);
    check({tag, "_state"}, 32'(state_dbg), 32'd6);
  endtask

  initial begin
    // Directed program: arithmetic, store/load, branches, jal/jr.
    enter_reset();
    mem[0]  = enc_i(8, 0, 1, 5);
    mem[1]  = enc_i(8, 0, 2, 7);
    mem[2]  = enc_r(1, 2, 3, 0, 'h20);
    mem[3]  = enc_i('h2B, 0, 1, 8);
    mem[4]  = enc_i('h23, 0, 4, 8);
    mem[5]  = enc_i(4, 1, 4, 2);
    mem[6]  = 32'hFC00_0000;
    mem[7]  = 32'hFC00_0000;
    mem[8]  = enc_i(5, 1, 4, 2);
    mem[9]  = enc_j(3, 'h40);
    mem[10] = enc_r(3, 1, 5, 0, 'h22);
    mem[11] = enc_j(2, 11);
    mem[64] = enc_r(31, 0, 0, 0, 'h08);
    hold_en = 1'b1; hold_addr = 32'h8; hold_delay = 3;
    release_reset();
    run(11, 300);
    check("dir_r1", dut.rf_q[1], 32'd5);
    check("dir_r3", dut.rf_q[3], 32'd12);
    check("dir_r4", dut.rf_q[4], 32'd5);
    check("dir_r5", dut.rf_q[5], 32'd7);
    check("dir_r31", dut.rf_q[31], 32'h28);
    check("dir_waddr", last_waddr, 32'h8);
    check("dir_wdata", last_wdata, 32'd5);
    check("dir_nwrites", 32'(n_writes), 32'd1);
    check_regs("dir_regs");

    // Illegal opcode and misaligned load both park in TRAP without a data access.
    enter_reset();
    mem[0] = 32'hFC00_0000;
    release_reset();
    check_trap("illegal");
    enter_reset();
    mem[0] = enc_i('h23, 0, 1, 6);
    release_reset();
    check_trap("misalign");

    // Random program with random wait states.
    enter_reset();
    for (int w = 0; w < 127; w++) begin
      int k = $urandom_range(0, 9);
      int t = $urandom_range(0, 127);
      case (k)
        0, 1: mem[w] = enc_r($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                             0, 32'(alu_fns[$urandom_range(0, 4)]));
        2: mem[w] = enc_r(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31),
                          $urandom_range(0, 1) ? 'h02 : 'h00);
        3: mem[w] = enc_i(8, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 65535));
        4: mem[w] = enc_i('h23, 0, $urandom_range(0, 15), 'h800 + 4 * $urandom_range(0, 255));
        5: mem[w] = enc_i('h2B, 0, $urandom_range(0, 15), 'h800 + 4 * $urandom_range(0, 255));
        6: mem[w] = enc_i($urandom_range(0, 1) ? 4 : 5, $urandom_range(0, 3), $urandom_range(0, 3),
                          t - (w + 1));
        7: mem[w] = enc_j(2, t);
        8: mem[w] = enc_j(3, t);
        default: mem[w] = enc_r(31, 0, 0, 0, 'h08);
      endcase
    end
    mem[127] = enc_j(2, 0);
    for (int i = 512; i < 1024; i++) mem[i] = $urandom;
    rand_waits = 1'b1;
    release_reset();
    run(600, 12000);
    check_regs("rand_regs");
    for (int i = 512; i < 1024; i++) check("rand_mem", mem[i], mmem[i]);

    // Reset during a stalled fetch aborts it; the core then restarts cleanly.
    enter_reset();
    mem[0] = enc_i(8, 0, 1, 5);
    hold_en = 1'b1; hold_addr = 32'h0; hold_delay = 50;
    release_reset();
    repeat (3) tick();
    check("abort_req_before", 32'(mem_req), 32'd1);
    enter_reset();
    mem[0] = enc_i(8, 0, 1, 5);
    mem[1] = enc_j(2, 1);
    release_reset();
    run(1, 50);
    check("abort_r1", dut.rf_q[1], 32'd5);
    check("abort_pc", pcout, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
